input_port_buffer: RTL and testbench

Per-port input FIFO and route-request stage of the NoC router. It buffers incoming single-flit packets and presents the head flit's relative address to the router's address computation. It latches the resulting one-hot request vector and updated address, then holds the request toward the output arbiters until granted. On grant it pops the head and launches the flit with its decremented address toward the crossbar.

---
 rtl/noc_pkg.sv | 31 +++
 rtl/ibuf_fifo.sv | 50 +++++
 rtl/input_port_buffer.sv | 121 ++++++++++++
 tb/tb_input_port_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router constants: port indices, request-vector bit positions
// and the input-buffer state encoding.
package noc_pkg;

   localparam int unsigned PORT_LOCAL = 1;
   localparam int unsigned PORT_NORTH = 2;
   localparam int unsigned PORT_SOUTH = 3;
   localparam int unsigned PORT_EAST  = 4;
   localparam int unsigned PORT_WEST  = 5;

   localparam int unsigned REQ_LOCAL = 0;
   localparam int unsigned REQ_NORTH = 1;
   localparam int unsigned REQ_SOUTH = 2;
   localparam int unsigned REQ_EAST  = 3;
   localparam int unsigned REQ_WEST  = 4;
   localparam int unsigned REQ_W     = 5;

   typedef enum logic [1:0] {
      IDLE,
      ROUTE,
      REQ
   } ibuf_state_e;

   function automatic logic req_hit(
      input logic [REQ_W-1:0] g,
      input logic [REQ_W-1:0] r
   );
      return |(g & r);
   endfunction

endpackage

// File: rtl/ibuf_fifo.sv
// Input-buffer storage: circular array with read/write pointers and count.
// A push is refused at full even when a pop happens in the same cycle.
module ibuf_fifo #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: empty entries are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/input_port_buffer.sv
// NoC router input port: FIFO plus route-request FSM toward the arbiters.
// Optional IBUF_OCCUPANCY_EN adds occupancy and full_stall_count outputs.
module input_port_buffer
   import noc_pkg::*;
#(
   parameter  int unsigned address_length = 16,
   parameter  int unsigned payload_length = 16,
   parameter  int unsigned depth          = 4,
   localparam int unsigned FW = payload_length + address_length,
   localparam int unsigned CW = $clog2(depth) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [FW-1:0]             in_flit,
   output logic                      in_ready,
   output logic [address_length-1:0] head_address,
   input  logic [REQ_W-1:0]          route_request_vector,
   input  logic [address_length-1:0] route_next_address,
   output logic [REQ_W-1:0]          request,
   input  logic [REQ_W-1:0]          grant,
   output logic                      out_valid,
   output logic [FW-1:0]             out_flit
`ifdef IBUF_OCCUPANCY_EN
   ,
   output logic [CW-1:0]             occupancy,
   output logic [15:0]               full_stall_count
`endif
);

   logic                      full;
   logic                      empty;
   logic [FW-1:0]             head;
   logic [CW-1:0]             count;
   logic                      push;
   logic                      pop;

   ibuf_state_e               state_q;
   logic [REQ_W-1:0]          req_q;
   logic [address_length-1:0] addr_q;
   logic [REQ_W-1:0]          request_q;
   logic                      out_valid_q;
   logic [FW-1:0]             out_flit_q;

   assign in_ready     = !full && !rst;
   assign push         = in_valid && in_ready;
   assign pop          = (state_q == REQ) && req_hit(grant, req_q);
   assign head_address = empty ? '0 : head[address_length-1:0];
   assign request      = request_q;
   assign out_valid    = out_valid_q;
   assign out_flit     = out_flit_q;

   ibuf_fifo #(
      .WIDTH (FW),
      .DEPTH (depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (in_flit),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         req_q       <= '0;
         addr_q      <= '0;
         request_q   <= '0;
         out_valid_q <= 1'b0;
         out_flit_q  <= '0;
      end else begin
         out_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!empty) state_q <= ROUTE;
            end
            ROUTE: begin
               req_q     <= route_request_vector;
               addr_q    <= route_next_address;
               request_q <= route_request_vector;
               state_q   <= REQ;
            end
            REQ: begin
               if (pop) begin
                  request_q   <= '0;
                  out_valid_q <= 1'b1;
                  out_flit_q  <= {head[FW-1:address_length], addr_q};
                  // Re-route if anything is left once the head is gone.
                  state_q     <= (count > CW'(1) || push) ? ROUTE : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef IBUF_OCCUPANCY_EN
   logic [15:0] stall_q;
   logic [15:0] stall_d;

   always_comb begin
      stall_d = stall_q;
      if (in_valid && !in_ready && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign occupancy        = count;
   assign full_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer: route vectors table, scoreboard on out_flit,
// plus full, grant-mismatch, back-to-back and reset sequences.
module tb_input_port_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_flit = '0;
   logic        in_ready;
   logic [15:0] head_address;
   logic [4:0]  route_request_vector;
   logic [15:0] route_next_address;
   logic [4:0]  request;
   logic [4:0]  grant = '0;
   logic        out_valid;
   logic [31:0] out_flit;
`ifdef IBUF_OCCUPANCY_EN
   logic [2:0]  occupancy;
   logic [15:0] full_stall_count;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_ov  = 0;
   int last_ov = -1;
   bit spacing_en = 1'b0;
   logic [31:0] sb[$];
   logic [31:0] exp_f;

   typedef struct {
      logic [15:0] payload;
      logic [15:0] addr;
      logic [4:0]  exp_req;
      logic [15:0] exp_next;
   } vec_t;
   vec_t vecs[6];

   input_port_buffer dut (
      .clk                  (clk),
      .rst                  (rst),
      .in_valid             (in_valid),
      .in_flit              (in_flit),
      .in_ready             (in_ready),
      .head_address         (head_address),
      .route_request_vector (route_request_vector),
      .route_next_address   (route_next_address),
      .request              (request),
      .grant                (grant),
      .out_valid            (out_valid),
      .out_flit             (out_flit)
`ifdef IBUF_OCCUPANCY_EN
      ,
      .occupancy            (occupancy),
      .full_stall_count     (full_stall_count)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in for the router's XY route computation.
   logic signed [7:0] hx;
   logic signed [7:0] hy;
   always_comb begin
      hx = head_address[7:0];
      hy = head_address[15:8];
      route_request_vector = 5'b00001;
      route_next_address   = head_address;
      if (hx > 0) begin
         route_request_vector = 5'b01000;
         route_next_address   = {hy, 8'(hx - 8'sd1)};
      end else if (hx < 0) begin
         route_request_vector = 5'b10000;
         route_next_address   = {hy, 8'(hx + 8'sd1)};
      end else if (hy > 0) begin
         route_request_vector = 5'b00010;
         route_next_address   = {8'(hy - 8'sd1), hx};
      end else if (hy < 0) begin
         route_request_vector = 5'b00100;
         route_next_address   = {8'(hy + 8'sd1), hx};
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (out_valid) begin
         n_ov++;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got=%h want=none", out_flit);
         end else begin
            exp_f = sb.pop_front();
            if (out_flit !== exp_f) begin
               bad++;
               $display("FAIL sb_flit got=%h want=%h", out_flit, exp_f);
            end
         end
         if (spacing_en && last_ov >= 0)
            chk("ov_spacing", 32'(cyc - last_ov), 32'd2);
         last_ov = cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{16'h1111, 16'h0002, 5'b01000, 16'h0001};
      vecs[1] = '{16'h2222, 16'h00FF, 5'b10000, 16'h0000};
      vecs[2] = '{16'h3333, 16'h0100, 5'b00010, 16'h0000};
      vecs[3] = '{16'h4444, 16'hFD00, 5'b00100, 16'hFE00};
      vecs[4] = '{16'h5555, 16'h0000, 5'b00001, 16'h0000};
      vecs[5] = '{16'h6666, 16'h0205, 5'b01000, 16'h0204};

      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_request", request, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_flit", out_flit, 0);
      chk("rst_head", head_address, 0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", in_ready, 1);

      // Single-flit route/request/launch per vector.
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_flit  = {vecs[i].payload, vecs[i].addr};
         tick();
         in_valid = 1'b0;
         chk("vec_head", head_address, vecs[i].addr);
         tick();
         chk("vec_req_early", request, 0);
         tick();
         chk("vec_req", request, vecs[i].exp_req);
         sb.push_back({vecs[i].payload, vecs[i].exp_next});
         grant = vecs[i].exp_req;
         tick();
         grant = '0;
         chk("vec_req_drop", request, 0);
         tick();
      end

      // Fill to full with no grant; the extra flit must be refused.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_flit  = {16'hA0 + 16'(i), 16'h0001};
         chk("fill_ready", in_ready, 1);
         sb.push_back({16'hA0 + 16'(i), 16'h0000});
         tick();
      end
      in_flit = {16'hDEAD, 16'h0001};
      chk("full_ready0", in_ready, 0);
      tick();
      chk("full_ready1", in_ready, 0);
      tick();
      chk("full_req", request, 5'b01000);
      grant = 5'b01000;
      tick();
      grant = '0;
      in_valid = 1'b0;
      chk("ready_after_pop", in_ready, 1);

      // Drain with grant held: one launch every 2 cycles, FIFO order.
      spacing_en = 1'b1;
      last_ov = -1;
      grant = 5'b01000;
      for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
      chk("drain_done", sb.size(), 0);
      grant = '0;
      spacing_en = 1'b0;
      tick();
      tick();
      chk("drain_idle_req", request, 0);
      chk("drain_head", head_address, 0);

      // Grant outside the request is ignored.
      in_valid = 1'b1;
      in_flit  = {16'h5A5A, 16'h0100};
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("mis_req", request, 5'b00010);
      grant = 5'b01000;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mis_hold", request, 5'b00010);
      end
      grant = '0;
      sb.push_back({16'h5A5A, 16'h0000});
      grant = 5'b00010;
      tick();
      grant = '0;
      chk("mis_pop_req", request, 0);
      tick();

      // Asynchronous reset while requesting with two flits queued.
      in_valid = 1'b1;
      in_flit  = {16'h7001, 16'h0001};
      tick();
      in_flit  = {16'h7002, 16'h0002};
      tick();
      in_valid = 1'b0;
      tick();
      chk("pre_rst_req", request, 5'b01000);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_request", request, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_head", head_address, 0);
      for (int k = 0; k < 3; k++) tick();
      chk("post_rst_idle", request, 0);

`ifdef IBUF_OCCUPANCY_EN
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_flit  = {16'hB0 + 16'(i), 16'h0001};
         tick();
      end
      for (int k = 0; k < 5; k++) tick();
      in_valid = 1'b0;
      chk("stall_count", full_stall_count, 16'd5);
      chk("occupancy", occupancy, 3'd4);
      rst = 1'b1;
      tick();
      chk("occ_rst", occupancy, 0);
      chk("stall_rst", full_stall_count, 0);
      rst = 1'b0;
      tick();
`endif

      tick();
      chk("sb_empty", sb.size(), 0);
      chk("launch_count", n_ov, 11);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
